// File: rtl/rf_pkg.sv
// Shared sizing and encoding constants for the register-file writeback scheduler.
package rf_pkg;
    localparam int RF_NUM_REGS        = 32;
    localparam int RF_ADDR_W          = 5;
    localparam int RF_DATA_W          = 32;
    localparam int RF_MAX_OUTSTANDING = 4;
    localparam int RF_OUT_W           = 3;
    localparam int ZERO_REG           = 0;

    localparam logic GRANT_WB0 = 1'b0;
    localparam logic GRANT_WB1 = 1'b1;
endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits, outstanding-write counter and issue hazard detection.
module rf_scoreboard import rf_pkg::*; #(
    parameter int NUM_REGS        = RF_NUM_REGS,
    parameter int ADDR_W          = RF_ADDR_W,
    parameter int MAX_OUTSTANDING = RF_MAX_OUTSTANDING,
    parameter int HARDWIRE_ZERO   = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   rs1_i,
    input  logic [ADDR_W-1:0]   rs2_i,
    input  logic [ADDR_W-1:0]   rd_i,
    input  logic                wen_i,
    input  logic                issue_i,
    input  logic                clr_i,
    input  logic [ADDR_W-1:0]   clr_idx_i,
    output logic [NUM_REGS-1:0] busy_o,
    output logic [RF_OUT_W-1:0] outstanding_o,
    output logic                hazard_o
);
    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [RF_OUT_W-1:0] cnt_q, cnt_d;
    logic                set_en, clr_en, cnt_full;

    assign cnt_full = (cnt_q == RF_OUT_W'(MAX_OUTSTANDING));
    assign hazard_o = busy_q[rs1_i] | busy_q[rs2_i] | (wen_i & (busy_q[rd_i] | cnt_full));
    assign set_en   = issue_i & wen_i & ~((HARDWIRE_ZERO != 0) && (rd_i == ADDR_W'(ZERO_REG)));
    // Only a pending bit can be retired, so a stray commit never drops the count.
    assign clr_en   = clr_i & busy_q[clr_idx_i];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_busy
            // Set beats clear when issue and commit hit the same register.
            assign busy_d[gi] = (set_en && (rd_i == ADDR_W'(gi))) |
                                (busy_q[gi] & ~(clr_en && (clr_idx_i == ADDR_W'(gi))));
        end
    endgenerate

    always_comb begin
        cnt_d = cnt_q;
        if (set_en && !clr_en) begin
            cnt_d = cnt_q + 1'b1;
        end else if (clr_en && !set_en && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy_o        = busy_q;
    assign outstanding_o = cnt_q;
endmodule

// File: rtl/rf_wb_scheduler.sv
// Issue-hazard gate plus round-robin arbitration of two writeback sources onto
// the register file's single registered write port.
module rf_wb_scheduler import rf_pkg::*; #(
    parameter int NUM_REGS        = RF_NUM_REGS,
    parameter int ADDR_W          = RF_ADDR_W,
    parameter int DATA_W          = RF_DATA_W,
    parameter int MAX_OUTSTANDING = RF_MAX_OUTSTANDING,
    parameter int HARDWIRE_ZERO   = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                iss_valid,
    output logic                iss_ready,
    input  logic [ADDR_W-1:0]   iss_rs1,
    input  logic [ADDR_W-1:0]   iss_rs2,
    input  logic [ADDR_W-1:0]   iss_rd,
    input  logic                iss_wen,
    input  logic                wb0_valid,
    output logic                wb0_ready,
    input  logic [ADDR_W-1:0]   wb0_rd,
    input  logic [DATA_W-1:0]   wb0_data,
    input  logic                wb1_valid,
    output logic                wb1_ready,
    input  logic [ADDR_W-1:0]   wb1_rd,
    input  logic [DATA_W-1:0]   wb1_data,
    output logic [ADDR_W-1:0]   PR1,
    output logic [ADDR_W-1:0]   PR2,
    output logic                write,
    output logic [ADDR_W-1:0]   WR,
    output logic [DATA_W-1:0]   WD,
    output logic [RF_OUT_W-1:0] outstanding,
    output logic                wb_err
);
    logic [NUM_REGS-1:0] busy;
    logic                hazard, issue_fire;
    logic                last_grant_q, last_grant_d;
    logic                gnt0, gnt1, gnt_any, gnt_zero, gnt_live, gnt_err;
    logic [ADDR_W-1:0]   gnt_rd;
    logic [DATA_W-1:0]   gnt_data;
    logic                write_q, write_d, wb_err_q, wb_err_d;
    logic [ADDR_W-1:0]   wr_q, wr_d;
    logic [DATA_W-1:0]   wd_q, wd_d;

    assign PR1        = iss_rs1;
    assign PR2        = iss_rs2;
    assign iss_ready  = ~hazard & ~reset;
    assign issue_fire = iss_valid & iss_ready;

    rf_scoreboard #(
        .NUM_REGS        (NUM_REGS),
        .ADDR_W          (ADDR_W),
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .HARDWIRE_ZERO   (HARDWIRE_ZERO)
    ) u_scoreboard (
        .clk           (clk),
        .reset         (reset),
        .rs1_i         (iss_rs1),
        .rs2_i         (iss_rs2),
        .rd_i          (iss_rd),
        .wen_i         (iss_wen),
        .issue_i       (issue_fire),
        .clr_i         (write_q),
        .clr_idx_i     (wr_q),
        .busy_o        (busy),
        .outstanding_o (outstanding),
        .hazard_o      (hazard)
    );

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset) begin
            if (wb0_valid && wb1_valid) begin
                gnt0 = (last_grant_q == GRANT_WB1);
                gnt1 = (last_grant_q == GRANT_WB0);
            end else begin
                gnt0 = wb0_valid;
                gnt1 = wb1_valid;
            end
        end
    end

    assign wb0_ready = gnt0;
    assign wb1_ready = gnt1;
    assign gnt_any   = gnt0 | gnt1;
    assign gnt_rd    = gnt1 ? wb1_rd : wb0_rd;
    assign gnt_data  = gnt1 ? wb1_data : wb0_data;
    // A granted request is consumed either way; only a pending destination is written.
    assign gnt_zero  = (HARDWIRE_ZERO != 0) && (gnt_rd == ADDR_W'(ZERO_REG));
    assign gnt_live  = gnt_any & ~gnt_zero & busy[gnt_rd];
    assign gnt_err   = gnt_any & ~gnt_zero & ~busy[gnt_rd];

    always_comb begin
        last_grant_d = last_grant_q;
        if (gnt0) begin
            last_grant_d = GRANT_WB0;
        end else if (gnt1) begin
            last_grant_d = GRANT_WB1;
        end
        write_d  = gnt_live;
        wr_d     = gnt_live ? gnt_rd : wr_q;
        wd_d     = gnt_live ? gnt_data : wd_q;
        wb_err_d = wb_err_q | gnt_err;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= GRANT_WB1;
            write_q      <= 1'b0;
            wr_q         <= '0;
            wd_q         <= '0;
            wb_err_q     <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            write_q      <= write_d;
            wr_q         <= wr_d;
            wd_q         <= wd_d;
            wb_err_q     <= wb_err_d;
        end
    end

    assign write  = write_q;
    assign WR     = wr_q;
    assign WD     = wd_q;
    assign wb_err = wb_err_q;
endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Directed walk through the scheduler's main scenarios followed by randomized
// traffic, all checked against a cycle-level reference model.
module tb_rf_wb_scheduler;
    logic        clk = 1'b0;
    logic        reset;
    logic        iss_valid, iss_ready, iss_wen;
    logic [4:0]  iss_rs1, iss_rs2, iss_rd;
    logic        wb0_valid, wb0_ready, wb1_valid, wb1_ready;
    logic [4:0]  wb0_rd, wb1_rd;
    logic [31:0] wb0_data, wb1_data;
    logic [4:0]  PR1, PR2, WR;
    logic        write, wb_err;
    logic [31:0] WD;
    logic [2:0]  outstanding;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: pending-write set, count, arbiter history, write port.
    bit [31:0] m_busy;
    int        m_cnt;
    bit        m_last_wb1;
    bit        m_write;
    bit [4:0]  m_wr;
    bit [31:0] m_wd;
    bit        m_err;
    bit        m_g0, m_g1;

    logic [31:0] tb_rf [32];

    always #5 clk = ~clk;

    always @(posedge clk) if (write) tb_rf[WR] <= WD;

    rf_wb_scheduler dut (
        .clk(clk), .reset(reset),
        .iss_valid(iss_valid), .iss_ready(iss_ready),
        .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd), .iss_wen(iss_wen),
        .wb0_valid(wb0_valid), .wb0_ready(wb0_ready), .wb0_rd(wb0_rd), .wb0_data(wb0_data),
        .wb1_valid(wb1_valid), .wb1_ready(wb1_ready), .wb1_rd(wb1_rd), .wb1_data(wb1_data),
        .PR1(PR1), .PR2(PR2), .write(write), .WR(WR), .WD(WD),
        .outstanding(outstanding), .wb_err(wb_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock: check combinational outputs mid-cycle, advance model, check registers after the edge.
    task automatic run_cycle();
        bit        haz, live, zero;
        bit [4:0]  grd;
        bit [31:0] gdat;
        @(negedge clk);
        #1;
        haz = m_busy[iss_rs1] | m_busy[iss_rs2] |
              (iss_wen && (m_busy[iss_rd] || m_cnt == 4));
        m_g0 = 1'b0;
        m_g1 = 1'b0;
        if (!reset) begin
            if (wb0_valid && wb1_valid) begin
                if (m_last_wb1) m_g0 = 1'b1; else m_g1 = 1'b1;
            end else begin
                m_g0 = wb0_valid;
                m_g1 = wb1_valid;
            end
        end
        check_eq("iss_ready", iss_ready, 32'(!reset && !haz));
        check_eq("wb0_ready", wb0_ready, 32'(m_g0));
        check_eq("wb1_ready", wb1_ready, 32'(m_g1));
        check_eq("PR1", PR1, iss_rs1);
        check_eq("PR2", PR2, iss_rs2);

        if (reset) begin
            m_busy = '0; m_cnt = 0; m_write = 0; m_wr = '0; m_wd = '0;
            m_last_wb1 = 1'b1; m_err = 1'b0;
        end else begin
            grd  = m_g1 ? wb1_rd : wb0_rd;
            gdat = m_g1 ? wb1_data : wb0_data;
            zero = (grd == 5'd0);
            live = (m_g0 || m_g1) && !zero && m_busy[grd];
            if ((m_g0 || m_g1) && !zero && !m_busy[grd]) m_err = 1'b1;
            if (m_g0) m_last_wb1 = 1'b0;
            else if (m_g1) m_last_wb1 = 1'b1;
            if (m_write && m_busy[m_wr]) begin
                m_busy[m_wr] = 1'b0;
                m_cnt--;
            end
            if (iss_valid && !haz && iss_wen && iss_rd != 5'd0) begin
                m_busy[iss_rd] = 1'b1;
                m_cnt++;
            end
            m_write = live;
            if (live) begin
                m_wr = grd;
                m_wd = gdat;
            end
        end

        @(posedge clk);
        #1;
        check_eq("write", write, 32'(m_write));
        if (m_write) begin
            check_eq("WR", WR, 32'(m_wr));
            check_eq("WD", WD, m_wd);
        end
        check_eq("outstanding", outstanding, 32'(m_cnt));
        check_eq("wb_err", wb_err, 32'(m_err));
    endtask

    task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic wen);
        iss_valid = 1'b1; iss_rs1 = rs1; iss_rs2 = rs2; iss_rd = rd; iss_wen = wen;
        run_cycle();
        iss_valid = 1'b0;
        $display("issue rs1=%0d rs2=%0d rd=%0d wen=%0d -> outstanding=%0d", rs1, rs2, rd, wen, outstanding);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        run_cycle();
        reset = 1'b0;
    endtask

    function automatic logic [4:0] pick_rd();
        int s = int'($urandom_range(0, 31));
        if ($urandom_range(0, 9) < 8) begin
            for (int k = 0; k < 32; k++) begin
                if (m_busy[(s + k) % 32]) return 5'((s + k) % 32);
            end
        end
        return 5'($urandom_range(0, 15));
    endfunction

    initial begin
        reset = 1'b1;
        iss_valid = 0; iss_wen = 0; iss_rs1 = 0; iss_rs2 = 0; iss_rd = 0;
        wb0_valid = 0; wb0_rd = 0; wb0_data = 0;
        wb1_valid = 0; wb1_rd = 0; wb1_data = 0;
        m_busy = '0; m_cnt = 0; m_write = 0; m_wr = '0; m_wd = '0; m_last_wb1 = 1; m_err = 0;

        run_cycle();
        run_cycle();
        check_eq("rst_WR", WR, 32'd0);
        check_eq("rst_WD", WD, 32'd0);
        reset = 1'b0;

        // Issue with a destination, then a dependent read stalls.
        issue(5'd6, 5'd8, 5'd4, 1'b1);
        check_eq("t1_outstanding", outstanding, 32'd1);
        iss_rs1 = 5'd4; iss_rs2 = 5'd0; iss_wen = 1'b0;
        #1 check_eq("t1_hazard", iss_ready, 32'd0);

        // Writeback latency and release of the dependent read.
        wb0_valid = 1'b1; wb0_rd = 5'd4; wb0_data = 32'd31;
        run_cycle();
        wb0_valid = 1'b0;
        check_eq("t2_write", write, 32'd1);
        check_eq("t2_WR", WR, 32'd4);
        check_eq("t2_WD", WD, 32'd31);
        run_cycle();
        iss_rs1 = 5'd4;
        #1 check_eq("t2_ready", iss_ready, 32'd1);
        check_eq("t2_rf_read", tb_rf[PR1], 32'd31);
        $display("writeback rd=4 data=31 committed");

        // Simultaneous requests after reset: wb0 first, then wb1.
        pulse_reset();
        issue(5'd0, 5'd0, 5'd10, 1'b1);
        issue(5'd0, 5'd0, 5'd12, 1'b1);
        wb0_valid = 1; wb0_rd = 5'd10; wb0_data = 32'd100;
        wb1_valid = 1; wb1_rd = 5'd12; wb1_data = 32'd200;
        run_cycle();
        wb0_valid = 1'b0;
        check_eq("t3_first_WR", WR, 32'd10);
        run_cycle();
        wb1_valid = 1'b0;
        check_eq("t3_second_WR", WR, 32'd12);
        check_eq("t3_second_WD", WD, 32'd200);
        run_cycle();
        check_eq("t3_drained", outstanding, 32'd0);
        $display("tie arbitration rd=10 then rd=12 done");

        // Outstanding limit stalls only writing instructions.
        for (int r = 1; r <= 4; r++) issue(5'd0, 5'd0, 5'(r), 1'b1);
        check_eq("t4_full", outstanding, 32'd4);
        iss_rs1 = 5'd0; iss_rs2 = 5'd0; iss_rd = 5'd5; iss_wen = 1'b1;
        #1 check_eq("t4_stall_wen", iss_ready, 32'd0);
        iss_wen = 1'b0;
        #1 check_eq("t4_nowen_ok", iss_ready, 32'd1);
        issue(5'd0, 5'd0, 5'd5, 1'b0);
        for (int r = 1; r <= 4; r++) begin
            wb0_valid = 1'b1; wb0_rd = 5'(r); wb0_data = 32'(r * 3);
            run_cycle();
            wb0_valid = 1'b0;
        end
        run_cycle();
        check_eq("t4_drained", outstanding, 32'd0);

        // Stray writeback flags an error; rd=0 issue changes nothing.
        wb1_valid = 1'b1; wb1_rd = 5'd7; wb1_data = 32'hdead;
        run_cycle();
        wb1_valid = 1'b0;
        check_eq("t5_err", wb_err, 32'd1);
        check_eq("t5_nowrite", write, 32'd0);
        issue(5'd0, 5'd0, 5'd0, 1'b1);
        check_eq("t5_rd0_count", outstanding, 32'd0);
        run_cycle();
        check_eq("t5_err_sticky", wb_err, 32'd1);

        // Reset mid-operation.
        issue(5'd0, 5'd0, 5'd20, 1'b1);
        issue(5'd0, 5'd0, 5'd21, 1'b1);
        check_eq("t6_pending", outstanding, 32'd2);
        wb0_valid = 1'b1; wb0_rd = 5'd20; wb0_data = 32'd9;
        reset = 1'b1;
        #1 check_eq("t6_wb0_held", wb0_ready, 32'd0);
        run_cycle();
        reset = 1'b0;
        wb0_valid = 1'b0;
        check_eq("t6_count", outstanding, 32'd0);
        check_eq("t6_write", write, 32'd0);
        check_eq("t6_err_clr", wb_err, 32'd0);
        iss_rs1 = 5'd1; iss_wen = 1'b0;
        #1 check_eq("t6_ready", iss_ready, 32'd1);
        run_cycle();
        $display("reset mid-operation recovered");

        // Randomized traffic; requesters hold until granted.
        for (int c = 0; c < 3000; c++) begin
            reset     = ($urandom_range(0, 249) == 0);
            iss_valid = 1'($urandom_range(0, 1));
            iss_rs1   = 5'($urandom_range(0, 15));
            iss_rs2   = 5'($urandom_range(0, 15));
            iss_rd    = 5'($urandom_range(0, 15));
            iss_wen   = 1'($urandom_range(0, 1));
            if (!wb0_valid && $urandom_range(0, 2) == 0) begin
                wb0_valid = 1'b1; wb0_rd = pick_rd(); wb0_data = $urandom;
            end
            if (!wb1_valid && $urandom_range(0, 2) == 0) begin
                wb1_valid = 1'b1; wb1_rd = pick_rd(); wb1_data = $urandom;
            end
            run_cycle();
            if (m_g0) wb0_valid = 1'b0;
            if (m_g1) wb1_valid = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
